// File: rtl/ariane_pkg.sv
// Shared lane/word types and the pack-unit state encoding.
package ariane_pkg;
  localparam int LANE_W    = 8;
  localparam int LANES_DEF = 4;

  typedef logic [LANE_W-1:0]           lane_t;
  typedef logic [LANES_DEF*LANE_W-1:0] word_t;

  typedef enum logic {
    ST_FILL       = 1'b0,
    ST_FLUSH_WAIT = 1'b1
  } rq_state_t;
endpackage

// File: rtl/requant_sat.sv
// One-lane requantizer: arithmetic shift then clamp to a signed or unsigned byte.
// REQUANT_ROUND_EN adds round-half-up before the shift; without it the shift floors.
module requant_sat
  import ariane_pkg::*;
#(
  parameter int ACC_W = 32
) (
  input  logic [ACC_W-1:0] i_acc,
  input  logic [4:0]       i_shift,
  input  logic             i_unsigned,
  output lane_t            o_q,
  output logic             o_sat
);
  localparam int XW = ACC_W + 1;
  localparam logic signed [XW-1:0] S_MAX = XW'(127);
  localparam logic signed [XW-1:0] S_MIN = XW'(-128);
  localparam logic signed [XW-1:0] U_MAX = XW'(255);

  logic signed [XW-1:0] w_ext;
  logic signed [XW-1:0] w_shifted;

  // One extra bit keeps the rounding add from overflowing at the top of the range.
  assign w_ext = $signed({i_acc[ACC_W-1], i_acc});

`ifdef REQUANT_ROUND_EN
  logic signed [XW-1:0] w_rnd;
  assign w_rnd     = (i_shift == 5'd0) ? '0 : $signed(XW'(1) << (i_shift - 5'd1));
  assign w_shifted = (w_ext + w_rnd) >>> i_shift;
`else
  assign w_shifted = w_ext >>> i_shift;
`endif

  always_comb begin
    o_q   = w_shifted[7:0];
    o_sat = 1'b0;
    if (i_unsigned) begin
      if (w_shifted[XW-1]) begin
        o_q   = 8'h00;
        o_sat = 1'b1;
      end else if (w_shifted > U_MAX) begin
        o_q   = 8'hFF;
        o_sat = 1'b1;
      end
    end else begin
      if (w_shifted > S_MAX) begin
        o_q   = 8'h7F;
        o_sat = 1'b1;
      end else if (w_shifted < S_MIN) begin
        o_q   = 8'h80;
        o_sat = 1'b1;
      end
    end
  end
endmodule

// File: rtl/requant_pack_unit.sv
// Requantizes accumulator samples to bytes and packs LANES of them per output word.
// Rounding is enabled by defining REQUANT_ROUND_EN (handled inside requant_sat).
module requant_pack_unit
  import ariane_pkg::*;
#(
  parameter int ACC_W = 32,
  parameter int LANES = LANES_DEF
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic [ACC_W-1:0]        acc_i,
  input  logic [4:0]              shift_i,
  input  logic                    unsigned_i,
  input  logic                    flush_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [LANES*LANE_W-1:0] packed_o,
  output logic [LANES-1:0]        lane_mask_o,
  output logic [LANES-1:0]        sat_o,
  output logic                    dbg_state_o
);
  localparam int CW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int NW = $clog2(LANES + 1);
  localparam logic [CW-1:0] LAST = CW'(LANES - 1);

  // Handshake: a sample moves on in_valid_i & in_ready_o, a word on
  // out_valid_o & out_ready_i, both at the rising clk_i edge; a held word never changes.
  rq_state_t             r_state, w_next_state;
  logic [CW-1:0]         r_lane_cnt;
  lane_t [LANES-1:0]     r_buf, w_buf_next;
  logic [LANES-1:0]      r_buf_sat, w_sat_next;
  logic                  r_out_valid;
  lane_t [LANES-1:0]     r_out_data;
  logic [LANES-1:0]      r_out_mask, r_out_sat;

  lane_t                 w_q;
  logic                  w_sat;
  logic                  w_ready, w_accept, w_load_full, w_load_part;
  logic                  w_out_busy, w_drain;
  logic [NW-1:0]         w_count;
  logic [LANES-1:0]      w_part_mask;

  requant_sat #(.ACC_W(ACC_W)) u_sat (
    .i_acc      (acc_i),
    .i_shift    (shift_i),
    .i_unsigned (unsigned_i),
    .o_q        (w_q),
    .o_sat      (w_sat)
  );

  assign w_out_busy = r_out_valid & ~out_ready_i;
  assign w_drain    = r_out_valid & out_ready_i;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) r_state <= ST_FILL;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_ready      = 1'b0;
    w_accept     = 1'b0;
    w_load_full  = 1'b0;
    w_load_part  = 1'b0;
    case (r_state)
      ST_FILL: begin
        w_ready  = rst_i & ~((r_lane_cnt == LAST) & w_out_busy);
        w_accept = in_valid_i & w_ready;
        if (w_accept && (r_lane_cnt == LAST)) begin
          w_load_full = 1'b1;
        end else if (flush_i && ((r_lane_cnt != '0) || w_accept)) begin
          if (!w_out_busy) w_load_part  = 1'b1;
          else             w_next_state = ST_FLUSH_WAIT;
        end
      end
      ST_FLUSH_WAIT: begin
        if (w_drain) begin
          w_load_part  = 1'b1;
          w_next_state = ST_FILL;
        end
      end
      default: w_next_state = ST_FILL;
    endcase
  end

  // Buffer as it looks with this cycle's sample merged in, so a flush includes it.
  always_comb begin
    w_buf_next = r_buf;
    w_sat_next = r_buf_sat;
    if (w_accept) begin
      w_buf_next[r_lane_cnt] = w_q;
      w_sat_next[r_lane_cnt] = w_sat;
    end
    w_count = NW'(r_lane_cnt) + NW'(w_accept);
    for (int i = 0; i < LANES; i++) begin
      w_part_mask[i] = (i < int'(w_count));
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_lane_cnt <= '0;
      r_buf      <= '0;
      r_buf_sat  <= '0;
    end else if (w_load_full || w_load_part) begin
      r_lane_cnt <= '0;
      r_buf      <= '0;
      r_buf_sat  <= '0;
    end else if (w_accept) begin
      r_lane_cnt <= r_lane_cnt + 1'b1;
      r_buf      <= w_buf_next;
      r_buf_sat  <= w_sat_next;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_mask  <= '0;
      r_out_sat   <= '0;
    end else if (w_load_full) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_buf_next;
      r_out_mask  <= '1;
      r_out_sat   <= w_sat_next;
    end else if (w_load_part) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_buf_next;
      r_out_mask  <= w_part_mask;
      r_out_sat   <= w_sat_next & w_part_mask;
    end else if (w_drain) begin
      r_out_valid <= 1'b0;
    end
  end

  assign in_ready_o  = w_ready;
  assign out_valid_o = r_out_valid;
  assign packed_o    = r_out_data;
  assign lane_mask_o = r_out_mask;
  assign sat_o       = r_out_sat;
  assign dbg_state_o = r_state;
endmodule

// File: doc/requant_pack_unit.md
REQUANT_PACK_UNIT -- requirements
Module: requant_pack_unit

Interface
REQ-001 SHALL have parameter ACC_W, default 32, meaning signed accumulator input width.
REQ-002 SHALL have parameter LANES, default 4, meaning 8-bit lanes per packed output word (LANES*8 = 32).
REQ-003 SHALL have port clk_i, input, 1, meaning clock.
REQ-004 SHALL have port rst_i, input, 1, meaning reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid_i, input, 1, meaning accumulator sample valid.
REQ-006 SHALL have port in_ready_o, output, 1, meaning unit can accept the sample.
REQ-007 SHALL have port acc_i, input, ACC_W, meaning signed accumulator, e.g. a dot-product result.
REQ-008 SHALL have port shift_i, input, 5, meaning arithmetic right-shift amount, sampled with each accepted input.
REQ-009 SHALL have port unsigned_i, input, 1, meaning 1 = saturate to [0,255], 0 = saturate to [-128,127].
REQ-010 SHALL have port flush_i, input, 1, meaning emit the partially filled word.
REQ-011 SHALL have port out_valid_o, output, 1, meaning packed word valid.
REQ-012 SHALL have port out_ready_i, input, 1, meaning consumer accepts the word.
REQ-013 SHALL have port packed_o, output, 32, meaning packed word, lane 0 = bits [7:0].
REQ-014 SHALL have port lane_mask_o, output, LANES, meaning lanes holding valid data.
REQ-015 SHALL have port sat_o, output, LANES, meaning lane value was clamped.

Function
REQ-016 Input accepted on in_valid_i & in_ready_o; output transferred on out_valid_o & out_ready_i.
REQ-017 Per accepted sample: arithmetic shift of acc_i right by shift_i, computed at ACC_W+1 bits (no overflow), then clamp to the range set by unsigned_i; sat flag = clamp applied.
REQ-018 Quantized byte written to lane lane_cnt of the assembly buffer; lane_cnt counts 0..LANES-1, wraps to 0 after lane LANES-1.
REQ-019 On acceptance of lane LANES-1: assembly buffer, mask all-ones, and sat flags move to the output register; out_valid_o rises the next cycle (latency 1 cycle from last accept).
REQ-020 Output register holds stable while out_valid_o & !out_ready_i.
REQ-021 in_ready_o = 0 only when lane_cnt = LANES-1 and the output register is full and not draining, or in state FLUSH_WAIT.
REQ-022 Simultaneous output transfer and word completion: output register reloads, out_valid_o stays 1, no bubble.
REQ-023 States: FILL (normal) and FLUSH_WAIT (flush pending, output register busy).
REQ-024 flush_i in FILL with lane_cnt > 0: partial word moves to the output register when it is free; unused lanes = 0x00; lane_mask_o = filled lanes; lane_cnt -> 0.
REQ-025 flush_i with output register busy: enter FLUSH_WAIT; leave it on the cycle the output transfers, loading the partial word then.
REQ-026 flush_i with lane_cnt = 0 and no sample accepted in the same cycle: no output, no state change.
REQ-027 flush_i in the same cycle as an accepted sample: the sample is included first, then the flush applies; if that sample completes the word, the flush adds nothing.
REQ-028 shift_i = 0: value passes unshifted, then is clamped.

Reset
REQ-029 rst_i low SHALL immediately clear lane_cnt, the assembly buffer, and the output register, and return to FILL.
REQ-030 While in reset, out_valid_o=0, packed_o=0, lane_mask_o=0, sat_o=0, in_ready_o=0; partial words are discarded.
REQ-031 in_ready_o=1 on the first clock edge after rst_i deasserts.

Configuration
REQ-032 Macro REQUANT_ROUND_EN defined: add 2^(shift_i-1) before the shift when shift_i>0 (round half up), in ACC_W+1 bits.
REQ-033 Macro REQUANT_ROUND_EN undefined: plain arithmetic shift (floor); no rounding adder present.

Structure
REQ-034 Lane width (8), LANES default, lane typedef, and packed-word typedef SHALL live in ariane_pkg.
REQ-035 Shift/round/saturate datapath SHALL be sub-module requant_sat (combinational, one lane), instantiated once.

Verification
REQ-036 Signed, shift 0, inputs 1, 2, -1, 300 -> packed_o=0x7FFF0201, lane_mask_o=4'b1111, sat_o=4'b1000, out_valid_o one cycle after the 4th accept.
REQ-037 Shift 4, acc=40 and acc=-40 -> with REQUANT_ROUND_EN lanes 0x03 and 0xFE; without it, lanes 0x02 and 0xFD.
REQ-038 unsigned_i=1, inputs -5, 0, 255, 256 -> packed_o=0xFFFF0000, sat_o=4'b1001.
REQ-039 out_ready_i held low, 8 inputs offered -> first word held stable; 8th input stalls (in_ready_o=0); out_ready_i=1 -> both words delivered in order, no loss.
REQ-040 2 inputs (0x11, 0x22), then flush_i with output busy -> FLUSH_WAIT, then packed_o=0x00002211, lane_mask_o=4'b0011.
REQ-041 rst_i low after 3 inputs -> outputs 0 immediately; after release, 4 new inputs form a complete word with no stale lanes.
